// File: rtl/ram_pkg.sv
// Shared constants and address helpers for the multi-port word RAM and
// other shared bus slaves.
package ram_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // The span is computed one bit wider so that very large depths cannot wrap it to zero.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input int depth);
    logic [ADDR_W:0]   span;
    logic [ADDR_W-1:0] offset;
    span   = {{(ADDR_W-2){1'b0}}, 3'b100} << depth;
    offset = addr - base;
    return (addr >= base) && ({1'b0, offset} < span);
  endfunction

  function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] addr,
                                                   input logic [ADDR_W-1:0] base,
                                                   input int depth);
    logic [ADDR_W-1:0] offset;
    offset = addr - base;
    return (offset >> 2) & ((ADDR_W'(1) << depth) - ADDR_W'(1));
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among N requesters, search starting
// just after the most recent winner.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt     = '0;
    win_idx = last_grant;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % N);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        win_idx   = cand;
        found     = 1'b1;
      end
    end
  end

  // Resetting to N-1 gives port 0 first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IDX_W'(N - 1);
    end else if (advance && found) begin
      last_grant <= win_idx;
    end
  end
endmodule

// File: rtl/ram_multiport.sv
// Shared single-ported word RAM serving NPORTS valid/ready masters through a
// round-robin arbiter, with range checking and per-port registered results.
module ram_multiport
  import ram_pkg::*;
#(
  parameter int          NPORTS    = 2,
  parameter int          DEPTH     = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter string       INIT_FILE = ""
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPORTS-1:0]          mem_valid,
  output logic [NPORTS-1:0]          mem_ready,
  input  logic [ADDR_W*NPORTS-1:0]   mem_addr,
  input  logic [DATA_W*NPORTS-1:0]   mem_wdata,
  input  logic [STRB_W*NPORTS-1:0]   mem_wstrb,
  output logic [DATA_W*NPORTS-1:0]   mem_rdata,
  output logic [NPORTS-1:0]          mem_err
);
  localparam int WORDS = 1 << DEPTH;

  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] gnt;
  logic [NPORTS-1:0] ready_reg;
  logic              any_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;
  logic              sel_hit;
  logic [DEPTH-1:0]  sel_word;
  logic              wr_en;
  logic              hit_reg;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] mem [WORDS];

  // The ready mask stops a master that still holds valid after its ack from being re-granted.
  assign req = mem_valid & ~ready_reg;

  rr_arbiter #(.N(NPORTS)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (1'b1),
    .gnt     (gnt)
  );

  assign any_gnt = |gnt;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (gnt[p]) begin
        sel_addr  = mem_addr[ADDR_W*p +: ADDR_W];
        sel_wdata = mem_wdata[DATA_W*p +: DATA_W];
        sel_wstrb = mem_wstrb[STRB_W*p +: STRB_W];
      end
    end
    sel_hit  = in_range(sel_addr, BASE_ADDR, DEPTH);
    sel_word = DEPTH'(word_index(sel_addr, BASE_ADDR, DEPTH));
  end

  // A grant that lands on the same edge as reset must not touch the array.
  assign wr_en = any_gnt & sel_hit & (|sel_wstrb) & ~rst;

  // Read-before-write falls out of the registered read sampling the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (sel_wstrb[b]) begin
          mem[sel_word][8*b +: 8] <= sel_wdata[8*b +: 8];
        end
      end
    end
    rd_word <= mem[sel_word];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_reg <= '0;
      hit_reg   <= 1'b0;
    end else begin
      ready_reg <= gnt;
      hit_reg   <= sel_hit;
    end
  end

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
    logic [DATA_W-1:0] hold_reg;
    logic [DATA_W-1:0] rdata_out;

    // Only one port can be acked per cycle, so the shared read word is routed to that port alone.
    assign rdata_out = ready_reg[gi] ? (hit_reg ? rd_word : '0) : hold_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold_reg <= '0;
      end else if (ready_reg[gi]) begin
        hold_reg <= rdata_out;
      end
    end

    assign mem_rdata[DATA_W*gi +: DATA_W] = rdata_out;
    assign mem_ready[gi]                  = ready_reg[gi];
    assign mem_err[gi]                    = ready_reg[gi] & ~hit_reg;
  end
endmodule
